// File: rtl/dbus_responder.sv
// Data-bus responder: 64-bit word storage with byte-lane stores, a fixed
// accept-to-response latency and an access fault outside the address window.
package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_responder #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  dbus_pkg::dbus_req_t  dreq,
    output dbus_pkg::dbus_resp_t dresp,
    output logic                 access_fault
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [64:0] LIMIT    = {1'b0, BASE_ADDR} + 65'(DEPTH_WORDS) * 65'd8;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic [63:0]      addr_q, addr_d;
    logic [63:0]      wdata_q, wdata_d;
    logic [63:0]      rdata_q, rdata_d;
    logic [7:0]       strobe_q, strobe_d;
    logic             addr_ok_q, addr_ok_d;
    logic             data_ok_q, data_ok_d;
    logic             fault_q, fault_d;
    logic [63:0]      mem_q [DEPTH_WORDS];
    logic [63:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             wr_en;
    logic             unused_bits;

    // Range test uses 65-bit arithmetic so a window ending at 2^64 cannot wrap.
    assign offset      = addr_q - BASE_ADDR;
    assign idx         = offset[IDX_W+2:3];
    assign in_range    = (addr_q >= BASE_ADDR) && ({1'b0, addr_q} < LIMIT);
    assign unused_bits = ^{dreq.size, offset[63:IDX_W+3], offset[2:0]};

    // Handshake: dreq.valid is looked at only in IDLE. On acceptance the request
    // is latched and addr_ok pulses next cycle; dreq is then ignored until the
    // single data_ok cycle, which is the only cycle dresp.data is qualified.
    // The initiator holds valid until it sees data_ok; RESP is the last cycle
    // before data_ok shows, and the store commits on the edge that leaves it.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strobe_d  = strobe_q;
        rdata_d   = rdata_q;
        addr_ok_d = 1'b0;
        data_ok_d = 1'b0;
        fault_d   = 1'b0;
        wr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    addr_d    = dreq.addr;
                    wdata_d   = dreq.data;
                    strobe_d  = dreq.strobe;
                    addr_ok_d = 1'b1;
                    count_d   = CNT_INIT;
                    state_d   = (CNT_INIT == 4'd0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                count_d = count_q - 4'd1;
                if (count_d == 4'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                data_ok_d = 1'b1;
                fault_d   = !in_range;
                rdata_d   = in_range ? mem_q[idx] : 64'd0;
                wr_en     = in_range && (strobe_q != 8'd0);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            count_q   <= 4'd0;
            addr_q    <= 64'd0;
            wdata_q   <= 64'd0;
            strobe_q  <= 8'd0;
            rdata_q   <= 64'd0;
            addr_ok_q <= 1'b0;
            data_ok_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strobe_q  <= strobe_d;
            rdata_q   <= rdata_d;
            addr_ok_q <= addr_ok_d;
            data_ok_q <= data_ok_d;
            fault_q   <= fault_d;
        end
    end

    // Storage is not reset; a reset on the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (strobe_q[i]) begin
                    mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign dresp.addr_ok = addr_ok_q;
    assign dresp.data_ok = data_ok_q;
    assign dresp.data    = rdata_q;
    assign access_fault  = fault_q;
endmodule

// File: tb/tb_dbus_responder.sv
// Randomized bench for dbus_responder: two builds (LATENCY 2 and 1) checked
// against a sparse word-map model of the address window.
module tb_dbus_responder;
    import dbus_pkg::*;

    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int DEP0 = 512;
    localparam int DEP1 = 16;
    localparam int LAT0 = 2;
    localparam int LAT1 = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    dbus_req_t  dreq0, dreq1;
    dbus_resp_t dresp0, dresp1;
    logic       fault0, fault1;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] ref_mem [bit [64:0]];
    logic [63:0] exp_q [$];
    logic [63:0] last_rd [2];

    dbus_responder #(.DEPTH_WORDS(DEP0), .BASE_ADDR(BASE), .LATENCY(LAT0)) u_dut0 (
        .clk(clk), .reset(reset), .dreq(dreq0), .dresp(dresp0), .access_fault(fault0)
    );
    dbus_responder #(.DEPTH_WORDS(DEP1), .BASE_ADDR(BASE), .LATENCY(LAT1)) u_dut1 (
        .clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1), .access_fault(fault1)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, summary would be %0d compared / %0d wrong", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit in_window(input int sel, input logic [63:0] addr);
        logic [64:0] lim;
        lim = {1'b0, BASE} + 65'(8 * ((sel != 0) ? DEP1 : DEP0));
        return ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} < lim);
    endfunction

    function automatic logic [63:0] lane_mask(input logic [7:0] st);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{st[i]}};
        return m;
    endfunction

    function automatic logic [63:0] rand_addr(input int sel);
        int dep;
        dep = (sel != 0) ? DEP1 : DEP0;
        case ($urandom_range(0, 9))
            0: return BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
            1: return BASE + 64'(8 * dep) + 64'($urandom_range(0, 31));
            2: return {$urandom, $urandom};
            default: return BASE + 64'(8 * $urandom_range(0, dep - 1)) + 64'($urandom_range(0, 7));
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic set_req(input int sel, input dbus_req_t r);
        if (sel != 0) dreq1 = r;
        else          dreq0 = r;
    endtask

    function automatic dbus_resp_t resp_of(input int sel);
        return (sel != 0) ? dresp1 : dresp0;
    endfunction

    function automatic logic fault_of(input int sel);
        return (sel != 0) ? fault1 : fault0;
    endfunction

    // Called at a negedge; leaves the caller at the negedge showing data_ok.
    // keep=1 leaves valid high so the next txn call chains without a gap.
    task automatic txn(input int sel, input logic [63:0] addr, input logic [7:0] strobe,
                       input logic [63:0] data, input bit keep);
        dbus_req_t   r;
        dbus_resp_t  rs;
        bit          inr, known;
        bit [64:0]   k;
        logic [63:0] m;
        int          n, overlap;
        inr   = in_window(sel, addr);
        k     = {sel != 0, (addr - BASE) >> 3};
        known = inr ? ref_mem.exists(k) : 1'b1;
        if (known) exp_q.push_back(inr ? ref_mem[k] : 64'd0);
        if (inr && strobe != 8'd0) begin
            m = lane_mask(strobe);
            if (known) ref_mem[k] = (ref_mem[k] & ~m) | (data & m);
            else if (strobe == 8'hFF) ref_mem[k] = data;
        end
        r.valid = 1'b1; r.addr = addr; r.size = 3'($urandom_range(0, 3));
        r.strobe = strobe; r.data = data;
        set_req(sel, r);
        n = 0;
        do begin
            @(negedge clk); n++; rs = resp_of(sel);
        end while (!rs.addr_ok && n < 20);
        check_eq("accept_gap", 64'(n), 64'd1);
        n = 0; overlap = 0;
        do begin
            r.addr = {$urandom, $urandom}; r.data = {$urandom, $urandom};
            r.strobe = 8'($urandom);
            set_req(sel, r);
            @(negedge clk); n++; rs = resp_of(sel);
            if (rs.addr_ok && rs.data_ok) overlap++;
        end while (!rs.data_ok && n < 20);
        check_eq("latency", 64'(n), 64'((sel != 0) ? LAT1 : LAT0));
        check_eq("ok_overlap", 64'(overlap), 64'd0);
        check_eq("fault", 64'(fault_of(sel)), 64'(!inr));
        if (known) check_eq(inr ? "rdata" : "oor_rdata", rs.data, exp_q.pop_front());
        last_rd[sel] = rs.data;
        if (!keep) begin
            r.valid = 1'b0;
            set_req(sel, r);
        end
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(negedge clk);
        check_eq("hold0", dresp0.data, last_rd[0]);
        check_eq("hold1", dresp1.data, last_rd[1]);
        check_eq("idle_ok", 64'(dresp0.data_ok | dresp1.data_ok), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    logic [63:0] a_old;
    logic [63:0] a_mid;
    logic [7:0]  st;
    int          sel, len, seen, n;

    initial begin
        dreq0 = '0; dreq1 = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        dreq0.valid = 1'b1; dreq1.valid = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (dresp0.addr_ok || dresp1.addr_ok) seen++;
        end
        check_eq("rst_no_accept", 64'(seen), 64'd0);
        check_eq("rst_data_ok0", 64'(dresp0.data_ok), 64'd0);
        check_eq("rst_fault0", 64'(fault0), 64'd0);
        check_eq("rst_data0", dresp0.data, 64'd0);
        check_eq("rst_data_ok1", 64'(dresp1.data_ok), 64'd0);
        check_eq("rst_fault1", 64'(fault1), 64'd0);
        check_eq("rst_data1", dresp1.data, 64'd0);
        dreq0 = '0; dreq1 = '0;
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < DEP0; i++) txn(0, BASE + 64'(8 * i), 8'hFF, {$urandom, $urandom}, 1'b0);
        for (int i = 0; i < DEP1; i++) txn(1, BASE + 64'(8 * i), 8'hFF, {$urandom, $urandom}, 1'b0);

        // word store then load
        txn(0, 64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788, 1'b0);
        txn(0, 64'h8000_0010, 8'h00, 64'h0, 1'b0);
        check_eq("word_load", last_rd[0], 64'h1122_3344_5566_7788);

        // byte-lane merge
        txn(0, 64'h8000_0008, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        txn(0, 64'h8000_0008, 8'h0C, 64'h0000_0000_ABCD_0000, 1'b0);
        txn(0, 64'h8000_000C, 8'h00, 64'h0, 1'b0);
        check_eq("lane_merge", last_rd[0], 64'hFFFF_FFFF_ABCD_FFFF);

        // window edges
        txn(0, 64'h7FFF_FFF8, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1'b0);
        txn(0, BASE + 64'(8 * DEP0), 8'h00, 64'h0, 1'b0);
        txn(0, BASE + 64'(8 * DEP0), 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0);
        txn(0, 64'hFFFF_FFFF_FFFF_FFF8, 8'hFF, 64'h5555_5555_5555_5555, 1'b0);
        txn(0, BASE + 64'(8 * DEP0 - 8), 8'h00, 64'h0, 1'b0);
        txn(0, BASE, 8'h00, 64'h0, 1'b0);
        idle(2);

        // back-to-back loads with valid held throughout
        txn(0, 64'h8000_0010, 8'h00, 64'h0, 1'b1);
        txn(0, 64'h8000_0008, 8'h00, 64'h0, 1'b0);
        check_eq("b2b_second", last_rd[0], 64'hFFFF_FFFF_ABCD_FFFF);

        // reset while the store is in BUSY
        a_mid = BASE + 64'h100;
        a_old = ref_mem[{1'b0, (a_mid - BASE) >> 3}];
        dreq0.valid = 1'b1; dreq0.addr = a_mid; dreq0.strobe = 8'hFF; dreq0.data = ~a_old;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (!dresp0.addr_ok && n < 20);
        check_eq("mid_accept", 64'(n), 64'd1);
        reset = 1'b0; dreq0.valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_eq("mid_rst_data0", dresp0.data, 64'd0);
        check_eq("mid_rst_data1", dresp1.data, 64'd0);
        last_rd[0] = '0; last_rd[1] = '0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (dresp0.data_ok || fault0) seen++;
        end
        check_eq("mid_no_resp", 64'(seen), 64'd0);
        txn(0, a_mid, 8'h00, 64'h0, 1'b0);
        check_eq("mid_old_value", last_rd[0], a_old);

        // LATENCY=1 build
        txn(1, BASE + 64'h18, 8'hFF, 64'hCAFE_F00D_1234_5678, 1'b1);
        txn(1, BASE + 64'h18, 8'h00, 64'h0, 1'b1);
        txn(1, BASE + 64'h1F, 8'h00, 64'h0, 1'b0);
        check_eq("lat1_load", last_rd[1], 64'hCAFE_F00D_1234_5678);
        txn(1, BASE + 64'(8 * DEP1), 8'h00, 64'h0, 1'b0);
        idle(1);

        for (int it = 0; it < 400; it++) begin
            sel = ($urandom_range(0, 3) == 0) ? 1 : 0;
            len = $urandom_range(1, 3);
            for (int j = 0; j < len; j++) begin
                st = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
                txn(sel, rand_addr(sel), st, {$urandom, $urandom}, j < len - 1);
            end
            idle($urandom_range(1, 2));
        end

        for (int i = 0; i < DEP0; i++) txn(0, BASE + 64'(8 * i), 8'h00, 64'h0, 1'b0);
        for (int i = 0; i < DEP1; i++) txn(1, BASE + 64'(8 * i), 8'h00, 64'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
